// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state encoding for the handshaked Octa16 ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;  // ADD / SUB
  localparam logic [2:0] OP_LOG = 3'b001;  // NOR / NAND
  localparam logic [2:0] OP_SLT = 3'b010;  // SLTU / SLT
  localparam logic [2:0] OP_SH  = 3'b011;  // SRL / SLL
  localparam logic [2:0] OP_SRA = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_mul(input logic [2:0] op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/alu_seq_adder_n.sv
// WIDTH-bit adder with carry in/out, shared by add/sub/compare and the multiply accumulate.
module adder_n #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops plus a WIDTH-cycle shift-add multiply, registered result and flags.
import alu_pkg::*;

module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ctrl,
  input  logic             flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             carry,
  output logic             ovf
);

  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH - 1);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  state_t state_reg, state_next;
  logic [WIDTH-1:0]   out_reg;
  logic               zero_reg, carry_reg, ovf_reg;
  logic [WIDTH-1:0]   mcand_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [SHW:0]       cnt_reg;
  logic               mul_hi_reg;

  logic               accept;
  logic               sub_sel;
  logic [WIDTH-1:0]   add_a, add_b, add_sum;
  logic               add_cin, add_cout;
  logic               ovf_c, lt;
  logic [SHW-1:0]     sh;
  logic [WIDTH-1:0]   res;
  logic               res_carry, res_ovf;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mul_res;

  assign in_ready  = rst_n & ((state_reg == IDLE) | ((state_reg == DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_reg == DONE);
  assign out       = out_reg;
  assign zero      = zero_reg;
  assign carry     = carry_reg;
  assign ovf       = ovf_reg;

  // In BUSY the adder accumulates the partial product; otherwise it serves ADD/SUB/SLT.
  always_comb begin
    sub_sel = (ctrl == OP_ADD) ? flag : 1'b1;
    add_a   = a;
    add_b   = sub_sel ? ~b : b;
    add_cin = sub_sel;
    if (state_reg == BUSY) begin
      add_a   = acc_reg[2*WIDTH-1:WIDTH];
      add_b   = acc_reg[0] ? mcand_reg : '0;
      add_cin = 1'b0;
    end
  end

  adder_n #(.WIDTH(WIDTH)) u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign acc_next = {add_cout, add_sum, acc_reg[WIDTH-1:1]};
  assign mul_res  = mul_hi_reg ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];

  always_comb begin
    sh        = b[SHW-1:0];
    ovf_c     = (a[WIDTH-1] == add_b[WIDTH-1]) & (add_sum[WIDTH-1] != a[WIDTH-1]);
    lt        = flag ? (add_sum[WIDTH-1] ^ ovf_c) : ~add_cout;
    res       = '0;
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    case (ctrl)
      OP_ADD: begin
        res       = add_sum;
        res_carry = add_cout;
        res_ovf   = ovf_c;
      end
      OP_LOG:  res = flag ? ~(a & b) : ~(a | b);
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, lt};
      OP_SH:   res = flag ? (a << sh) : (a >> sh);
      OP_SRA:  res = $unsigned($signed(a) >>> sh);
      default: res = '0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = is_mul(ctrl) ? BUSY : DONE;
      BUSY: if (cnt_reg == CNT_LAST) state_next = DONE;
      DONE: begin
        if (accept)         state_next = is_mul(ctrl) ? BUSY : DONE;
        else if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      out_reg    <= '0;
      zero_reg   <= 1'b0;
      carry_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
      mcand_reg  <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      mul_hi_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == BUSY) begin
        acc_reg <= acc_next;
        cnt_reg <= cnt_reg + CNT_ONE;
        if (cnt_reg == CNT_LAST) begin
          out_reg   <= mul_res;
          zero_reg  <= (mul_res == '0);
          carry_reg <= 1'b0;
          ovf_reg   <= 1'b0;
        end
      end else if (accept) begin
        if (is_mul(ctrl)) begin
          // Multiplier sits in the low half and is consumed one bit per cycle.
          mcand_reg  <= a;
          acc_reg    <= {{WIDTH{1'b0}}, b};
          cnt_reg    <= '0;
          mul_hi_reg <= flag;
        end else begin
          out_reg   <= res;
          zero_reg  <= (res == '0);
          carry_reg <= res_carry;
          ovf_reg   <= res_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
`timescale 1ns/1ps

`define CHK(tag, fld, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errors++; \
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp); \
    end \
  end

`define R8(tag, eo, ef, el) \
  begin \
    `CHK(tag, "out", out8, eo) \
    `CHK(tag, "flags", {zero8, carry8, ovf8}, ef) \
    `CHK(tag, "lat", lat, el) \
  end

`define R16(tag, eo, ef, el) \
  begin \
    `CHK(tag, "out", out16, eo) \
    `CHK(tag, "flags", {zero16, carry16, ovf16}, ef) \
    `CHK(tag, "lat", lat, el) \
  end

module tb_alu_seq;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   lat;
    logic busy_ok;

    logic        in_valid8, in_ready8, flag8, out_valid8, out_ready8, zero8, carry8, ovf8;
    logic [2:0]  ctrl8;
    logic [7:0]  a8, b8, out8;
    logic        in_valid16, in_ready16, flag16, out_valid16, out_ready16, zero16, carry16, ovf16;
    logic [2:0]  ctrl16;
    logic [15:0] a16, b16, out16;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .ctrl(ctrl8), .flag(flag8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out(out8),
        .zero(zero8), .carry(carry8), .ovf(ovf8)
    );

    alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .ctrl(ctrl16), .flag(flag16),
        .out_valid(out_valid16), .out_ready(out_ready16), .out(out16),
        .zero(zero16), .carry(carry16), .ovf(ovf16)
    );

    task automatic issue8(input logic [2:0] c, input logic f, input logic [7:0] aa, input logic [7:0] bb);
        ctrl8 = c; flag8 = f; a8 = aa; b8 = bb; in_valid8 = 1'b1;
        `CHK("issue8", "in_ready", in_ready8, 1'b1)
        @(negedge clk);
        in_valid8 = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!out_valid8 && lat < 40) begin
            if (in_ready8 !== 1'b0) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        checks++;
        if (out_valid8 !== 1'b1) begin
            errors++;
            $error("FAIL issue8.timeout ctrl=%0h flag=%0b a=%0h b=%0h no out_valid after %0d cycles", c, f, aa, bb, lat);
        end
        $display("TXN w8  ctrl=%0h flag=%0b a=%0h b=%0h -> out=%0h z=%0b c=%0b v=%0b lat=%0d",
                 c, f, aa, bb, out8, zero8, carry8, ovf8, lat);
    endtask

    task automatic issue16(input logic [2:0] c, input logic f, input logic [15:0] aa, input logic [15:0] bb);
        ctrl16 = c; flag16 = f; a16 = aa; b16 = bb; in_valid16 = 1'b1;
        `CHK("issue16", "in_ready", in_ready16, 1'b1)
        @(negedge clk);
        in_valid16 = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!out_valid16 && lat < 60) begin
            if (in_ready16 !== 1'b0) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        checks++;
        if (out_valid16 !== 1'b1) begin
            errors++;
            $error("FAIL issue16.timeout ctrl=%0h flag=%0b a=%0h b=%0h no out_valid after %0d cycles", c, f, aa, bb, lat);
        end
        $display("TXN w16 ctrl=%0h flag=%0b a=%0h b=%0h -> out=%0h z=%0b c=%0b v=%0b lat=%0d",
                 c, f, aa, bb, out16, zero16, carry16, ovf16, lat);
    endtask

    task automatic take8();
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
    endtask

    task automatic take16();
        out_ready16 = 1'b1;
        @(negedge clk);
        out_ready16 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; ctrl8 = 3'b000; flag8 = 1'b0; a8 = '0; b8 = '0;
        in_valid16 = 1'b0; out_ready16 = 1'b0; ctrl16 = 3'b000; flag16 = 1'b0; a16 = '0; b16 = '0;

        repeat (3) @(negedge clk);
        checks++;
        if (out_valid8 !== 1'b0 || out8 !== 8'h00 || {zero8, carry8, ovf8} !== 3'b000 || in_ready8 !== 1'b0) begin
            errors++;
            $error("FAIL reset.state out_valid=%0b out=%0h flags=%0b in_ready=%0b",
                   out_valid8, out8, {zero8, carry8, ovf8}, in_ready8);
        end
        `CHK("reset", "out_valid", out_valid8, 1'b0)
        `CHK("reset", "out", out8, 8'h00)
        `CHK("reset", "flags", {zero8, carry8, ovf8}, 3'b000)
        `CHK("reset", "in_ready", in_ready8, 1'b0)
        rst_n = 1'b1;
        @(negedge clk);
        `CHK("post_reset", "in_ready", in_ready8, 1'b1)

        issue8(3'b000, 1'b1, 8'h05, 8'h07); `R8("sub", 8'hFE, 3'b000, 1) take8();
        issue8(3'b000, 1'b0, 8'h7F, 8'h01); `R8("add_ovf", 8'h80, 3'b001, 1) take8();
        issue8(3'b000, 1'b0, 8'hFF, 8'h01); `R8("add_carry", 8'h00, 3'b110, 1) take8();
        issue8(3'b010, 1'b1, 8'h80, 8'h01); `R8("slt", 8'h01, 3'b000, 1) take8();
        issue8(3'b010, 1'b0, 8'h80, 8'h01); `R8("sltu", 8'h00, 3'b100, 1) take8();
        issue8(3'b010, 1'b0, 8'h01, 8'h80); `R8("sltu_lt", 8'h01, 3'b000, 1) take8();

        issue8(3'b100, 1'b0, 8'h90, 8'h03); `R8("sra", 8'hF2, 3'b000, 1) take8();
        issue8(3'b001, 1'b1, 8'hF0, 8'h3C); `R8("nand", 8'hCF, 3'b000, 1) take8();
        issue8(3'b001, 1'b0, 8'hF0, 8'h3C); `R8("nor", 8'h03, 3'b000, 1) take8();
        issue8(3'b011, 1'b1, 8'h81, 8'h01); `R8("sll", 8'h02, 3'b000, 1) take8();
        issue8(3'b011, 1'b0, 8'h81, 8'h04); `R8("srl", 8'h08, 3'b000, 1) take8();
        issue8(3'b011, 1'b0, 8'hA5, 8'h08); `R8("srl_zero_amt", 8'hA5, 3'b000, 1) take8();
        issue8(3'b110, 1'b0, 8'hFF, 8'hFF); `R8("reserved", 8'h00, 3'b100, 1) take8();

        issue8(3'b101, 1'b0, 8'hFF, 8'hFF); `R8("mul_lo", 8'h01, 3'b000, 9)
        `CHK("mul_lo", "busy_rdy", busy_ok, 1'b1) take8();
        issue8(3'b101, 1'b1, 8'hFF, 8'hFF); `R8("mul_hi", 8'hFE, 3'b000, 9)
        `CHK("mul_hi", "busy_rdy", busy_ok, 1'b1) take8();
        issue8(3'b101, 1'b0, 8'h00, 8'h37); `R8("mul_zero", 8'h00, 3'b100, 9) take8();

        issue8(3'b000, 1'b0, 8'h10, 8'h20); `R8("bp_first", 8'h30, 3'b000, 1)
        ctrl8 = 3'b000; flag8 = 1'b0; a8 = 8'h11; b8 = 8'h22; in_valid8 = 1'b1;
        repeat (5) begin
            @(negedge clk);
            `CHK("bp_hold", "out", out8, 8'h30)
            `CHK("bp_hold", "out_valid", out_valid8, 1'b1)
            `CHK("bp_hold", "in_ready", in_ready8, 1'b0)
            $display("TXN w8  bp_hold out=%0h out_valid=%0b in_ready=%0b", out8, out_valid8, in_ready8);
        end
        out_ready8 = 1'b1;
        @(negedge clk);
        `CHK("bp_release", "out", out8, 8'h33)
        `CHK("bp_release", "out_valid", out_valid8, 1'b1)
        $display("TXN w8  bp_release out=%0h out_valid=%0b", out8, out_valid8);
        for (int i = 0; i < 4; i++) begin
            a8 = 8'(i); b8 = 8'h50;
            @(negedge clk);
            `CHK("stream", "out", out8, 8'h50 + 8'(i))
            `CHK("stream", "out_valid", out_valid8, 1'b1)
            $display("TXN w8  stream %0d out=%0h out_valid=%0b", i, out8, out_valid8);
        end
        in_valid8 = 1'b0;
        @(negedge clk);
        `CHK("stream_end", "out_valid", out_valid8, 1'b0)
        out_ready8 = 1'b0;

        ctrl8 = 3'b101; flag8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        `CHK("mid_rst", "out_valid", out_valid8, 1'b0)
        `CHK("mid_rst", "out", out8, 8'h00)
        `CHK("mid_rst", "flags", {zero8, carry8, ovf8}, 3'b000)
        `CHK("mid_rst", "in_ready", in_ready8, 1'b0)
        $display("TXN w8  mid_rst out=%0h out_valid=%0b", out8, out_valid8);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        `CHK("mid_rst_quiet", "out_valid", out_valid8, 1'b0)
        issue8(3'b000, 1'b0, 8'h03, 8'h04); `R8("after_rst_add", 8'h07, 3'b000, 1) take8();
        issue8(3'b101, 1'b0, 8'h0D, 8'h0B); `R8("after_rst_mul", 8'h8F, 3'b000, 9) take8();

        issue16(3'b000, 1'b1, 16'h0005, 16'h0007); `R16("sub16", 16'hFFFE, 3'b000, 1) take16();
        issue16(3'b000, 1'b0, 16'h7FFF, 16'h0001); `R16("add16_ovf", 16'h8000, 3'b001, 1) take16();
        issue16(3'b000, 1'b0, 16'hFFFF, 16'h0001); `R16("add16_carry", 16'h0000, 3'b110, 1) take16();
        issue16(3'b010, 1'b1, 16'h8000, 16'h0001); `R16("slt16", 16'h0001, 3'b000, 1) take16();
        issue16(3'b010, 1'b0, 16'h8000, 16'h0001); `R16("sltu16", 16'h0000, 3'b100, 1) take16();
        issue16(3'b100, 1'b0, 16'h9000, 16'h0003); `R16("sra16", 16'hF200, 3'b000, 1) take16();
        issue16(3'b101, 1'b0, 16'hFFFF, 16'hFFFF); `R16("mul16_lo", 16'h0001, 3'b000, 17)
        `CHK("mul16_lo", "busy_rdy", busy_ok, 1'b1) take16();
        issue16(3'b101, 1'b1, 16'hFFFF, 16'hFFFF); `R16("mul16_hi", 16'hFFFE, 3'b000, 17)
        `CHK("mul16_hi", "busy_rdy", busy_ok, 1'b1) take16();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
